// File: rtl/nand_cmd_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nand_arb_pkg: FSM state encoding and nand_master command codes.            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package nand_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESP   = 3'd4
  } arb_state_t;

  localparam logic [7:0] M_NAND_RESET                = 8'h01;
  localparam logic [7:0] M_NAND_READ_PARAM_PAGE      = 8'h02;
  localparam logic [7:0] M_NAND_READ_ID              = 8'h03;
  localparam logic [7:0] M_NAND_BLOCK_ERASE          = 8'h04;
  localparam logic [7:0] M_NAND_READ_STATUS          = 8'h05;
  localparam logic [7:0] M_NAND_READ                 = 8'h06;
  localparam logic [7:0] M_NAND_PAGE_PROGRAM         = 8'h07;
  localparam logic [7:0] MI_GET_STATUS               = 8'h08;
  localparam logic [7:0] MI_CHIP_ENABLE              = 8'h09;
  localparam logic [7:0] MI_CHIP_DISABLE             = 8'h0A;
  localparam logic [7:0] MI_WRITE_PROTECT            = 8'h0B;
  localparam logic [7:0] MI_WRITE_ENABLE             = 8'h0C;
  localparam logic [7:0] MI_RESET_INDEX              = 8'h0D;
  localparam logic [7:0] MI_GET_ID_BYTE              = 8'h0E;
  localparam logic [7:0] MI_GET_PARAM_PAGE_BYTE      = 8'h0F;
  localparam logic [7:0] MI_GET_DATA_PAGE_BYTE       = 8'h10;
  localparam logic [7:0] MI_SET_DATA_PAGE_BYTE       = 8'h11;
  localparam logic [7:0] MI_GET_CURRENT_ADDRESS_BYTE = 8'h12;
  localparam logic [7:0] MI_SET_CURRENT_ADDRESS_BYTE = 8'h13;

endpackage
`default_nettype wire

// File: rtl/nand_cmd_arbiter_rr_picker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_picker: combinational round-robin pick starting after last_grant.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module rr_picker #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] request,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic w_found;

  // Indices above last_grant first, then wrap around to 0..last_grant.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && request[i] && (IDX_W'(i) > last_grant)) begin
        grant[i]  = 1'b1;
        grant_idx = IDX_W'(i);
        w_found   = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && request[i]) begin
        grant[i]  = 1'b1;
        grant_idx = IDX_W'(i);
        w_found   = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/nand_cmd_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nand_cmd_arbiter: round-robin, lockable command sequencer for nand_master. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module nand_cmd_arbiter
  import nand_arb_pkg::*;
#(
  parameter  int NUM_REQ        = 4,
  parameter  int TIMEOUT_CYCLES = 4096,
  localparam int ID_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int TO_W           = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_lock,
  input  logic [NUM_REQ*8-1:0] req_cmd,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 rsp_valid,
  output logic [ID_W-1:0]      rsp_id,
  output logic [7:0]           rsp_data,
  output logic                 rsp_err,
  output logic [7:0]           m_cmd_in,
  output logic [7:0]           m_data_in,
  output logic                 m_activate,
  input  logic                 m_busy,
  input  logic [7:0]           m_data_out
);

  localparam logic [TO_W-1:0] c_to_last =
    TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  arb_state_t        r_state;
  logic [ID_W-1:0]   r_last_grant;
  logic              r_lock;
  logic [ID_W-1:0]   r_owner;
  logic [TO_W-1:0]   r_tcnt;
  logic [7:0]        r_cmd;
  logic [7:0]        r_data;
  logic              r_activate;
  logic              r_rsp_valid;
  logic [ID_W-1:0]   r_rsp_id;
  logic [7:0]        r_rsp_data;
  logic              r_rsp_err;

  logic                w_lock_held;
  logic [NUM_REQ-1:0]  w_owner_mask;
  logic [NUM_REQ-1:0]  w_eligible;
  logic [NUM_REQ-1:0]  w_pick;
  logic [ID_W-1:0]     w_pick_idx;
  logic                w_accept;
  logic                w_expired;

  // The lock only survives while its owner keeps req_lock asserted.
  assign w_lock_held = r_lock && req_lock[r_owner];

  always_comb begin
    w_owner_mask          = '0;
    w_owner_mask[r_owner] = 1'b1;
  end

  assign w_eligible = w_lock_held ? (req_valid & w_owner_mask) : req_valid;
  assign w_accept   = !reset && (r_state == ST_IDLE) && !m_busy && (|w_eligible);
  assign req_ready  = w_accept ? w_pick : '0;

  // r_tcnt counts completed WAIT cycles, so this is the TIMEOUT_CYCLES-th one.
  assign w_expired  = (TIMEOUT_CYCLES != 0) && (r_tcnt == c_to_last);

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .request    (w_eligible),
    .last_grant (r_last_grant),
    .grant      (w_pick),
    .grant_idx  (w_pick_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_last_grant <= ID_W'(NUM_REQ - 1);
      r_lock       <= 1'b0;
      r_owner      <= '0;
      r_tcnt       <= '0;
      r_cmd        <= 8'h00;
      r_data       <= 8'h00;
      r_activate   <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_data   <= 8'h00;
      r_rsp_err    <= 1'b0;
    end else begin
      r_activate  <= 1'b0;
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!w_lock_held) r_lock <= 1'b0;
          if (w_accept) begin
            r_cmd      <= req_cmd[{w_pick_idx, 3'b000} +: 8];
            r_data     <= req_data[{w_pick_idx, 3'b000} +: 8];
            r_rsp_id   <= w_pick_idx;
            r_activate <= 1'b1;
            r_state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_lock  <= req_lock[r_rsp_id];
          r_owner <= r_rsp_id;
          r_state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          r_tcnt  <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (!m_busy) begin
            r_rsp_data  <= m_data_out;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else if (w_expired) begin
            r_rsp_data  <= 8'h00;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else begin
            r_tcnt <= r_tcnt + TO_W'(1);
          end
        end
        ST_RESP: begin
          r_last_grant <= r_rsp_id;
          r_state      <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign m_cmd_in   = r_cmd;
  assign m_data_in  = r_data;
  assign m_activate = r_activate;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_data   = r_rsp_data;
  assign rsp_err    = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_nand_cmd_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | tb_nand_cmd_arbiter: self-checking bench with a behavioural nand_master.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_nand_cmd_arbiter;
  import nand_arb_pkg::*;

  localparam int N = 4;
  localparam logic [7:0] STATUS_VAL = 8'hA5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset;
  logic [N-1:0]   req_valid, req_lock;
  logic [N*8-1:0] req_cmd, req_data;
  logic           m_busy;
  logic [7:0]     m_data_out;

  logic [N-1:0] req_ready;
  logic         rsp_valid, rsp_err, m_activate;
  logic [1:0]   rsp_id;
  logic [7:0]   rsp_data, m_cmd_in, m_data_in;

  logic [N-1:0] to_req_ready;
  logic         to_rsp_valid, to_rsp_err, to_m_activate;
  logic [1:0]   to_rsp_id;
  logic [7:0]   to_rsp_data, to_m_cmd_in, to_m_data_in;

  int checks = 0;
  int failures = 0;

  nand_cmd_arbiter #(.NUM_REQ(N)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_lock(req_lock),
    .req_cmd(req_cmd), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .m_cmd_in(m_cmd_in), .m_data_in(m_data_in), .m_activate(m_activate),
    .m_busy(m_busy), .m_data_out(m_data_out)
  );

  nand_cmd_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) u_to (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_lock(req_lock),
    .req_cmd(req_cmd), .req_data(req_data), .req_ready(to_req_ready),
    .rsp_valid(to_rsp_valid), .rsp_id(to_rsp_id), .rsp_data(to_rsp_data), .rsp_err(to_rsp_err),
    .m_cmd_in(to_m_cmd_in), .m_data_in(to_m_data_in), .m_activate(to_m_activate),
    .m_busy(m_busy), .m_data_out(m_data_out)
  );

  // nand_master model: busy rises the cycle after activate and lasts busy_len cycles.
  int busy_len = 0;
  int bcnt;
  int id_ptr;
  logic [7:0] id_bytes [5] = '{8'h2C, 8'hE5, 8'hFF, 8'h03, 8'h86};

  function automatic logic [7:0] nand_fn(input logic [7:0] cmd, input logic [7:0] din);
    return cmd ^ din ^ 8'h3C;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      bcnt <= 0;
      m_data_out <= 8'h00;
      id_ptr <= 0;
    end else if (m_activate) begin
      bcnt <= busy_len;
      if (m_cmd_in == MI_GET_STATUS) m_data_out <= STATUS_VAL;
      else if (m_cmd_in == MI_GET_ID_BYTE) begin
        m_data_out <= (id_ptr < 5) ? id_bytes[id_ptr] : 8'h00;
        id_ptr <= id_ptr + 1;
      end else begin
        m_data_out <= nand_fn(m_cmd_in, m_data_in);
        if (m_cmd_in == M_NAND_READ_ID) id_ptr <= 0;
      end
    end else if (bcnt > 0) begin
      bcnt <= bcnt - 1;
    end
  end
  assign m_busy = (bcnt != 0);

  function automatic int rr_next(input logic [N-1:0] mask, input int last);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last + k) % N;
      if (mask[i]) return i;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0; req_lock = '0; req_cmd = '0; req_data = '0;
    busy_len = 0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b1;
    req_valid = '1;
    req_cmd = 32'($urandom);
    tick();
    @(negedge clk);
    checks++;
    if (req_ready !== '0) begin
      failures++; $display("FAIL reset_ready got=%b exp=0000", req_ready);
    end
    checks++;
    if ({m_activate, rsp_valid, rsp_err, rsp_id} !== 5'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=00000", {m_activate, rsp_valid, rsp_err, rsp_id});
    end
    checks++;
    if ({m_cmd_in, m_data_in, rsp_data} !== 24'h0) begin
      failures++; $display("FAIL reset_data got=%h exp=000000", {m_cmd_in, m_data_in, rsp_data});
    end
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0001;
    req_cmd[7:0] = MI_GET_STATUS;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c == 0) begin
        checks++;
        if (req_ready !== 4'b0001) begin
          failures++; $display("FAIL single_ready got=%b exp=0001", req_ready);
        end
      end
      checks++;
      if (m_activate !== (c == 1)) begin
        failures++; $display("FAIL single_activate cyc=%0d got=%b exp=%b", c, m_activate, (c == 1));
      end
      checks++;
      if (rsp_valid !== (c == 4)) begin
        failures++; $display("FAIL single_rsp_valid cyc=%0d got=%b exp=%b", c, rsp_valid, (c == 4));
      end
      if (c == 4) begin
        checks++;
        if (rsp_id !== 2'd0 || rsp_data !== 8'hA5 || rsp_err !== 1'b0) begin
          failures++; $display("FAIL single_rsp got id=%0d data=%h err=%b exp id=0 data=a5 err=0", rsp_id, rsp_data, rsp_err);
        end
      end
      tick();
      if (c == 0) req_valid = '0;
    end
  endtask

  task automatic test_round_robin();
    int last = N - 1;
    int ng = 0, nr = 0, g, eid;
    int q_id[$];
    logic [7:0] q_d[$];
    logic [7:0] ed;
    do_reset();
    for (int i = 0; i < N; i++) begin
      req_cmd[8*i +: 8]  = 8'(8'h60 + i);
      req_data[8*i +: 8] = 8'($urandom);
    end
    req_valid = '1;
    for (int c = 0; c < 100 && nr < 5; c++) begin
      @(negedge clk);
      g = -1;
      if (req_ready != '0 && ng < 5) begin
        g = rr_next(req_valid, last);
        checks++;
        if (req_ready !== (N'(1) << g)) begin
          failures++; $display("FAIL rr_grant n=%0d got=%b exp_idx=%0d", ng, req_ready, g);
        end
        q_id.push_back(g);
        q_d.push_back(nand_fn(req_cmd[8*g +: 8], req_data[8*g +: 8]));
        last = g;
        ng++;
      end
      if (rsp_valid) begin
        checks++;
        if (q_id.size() == 0) begin
          failures++; $display("FAIL rr_rsp unexpected id=%0d", rsp_id);
        end else begin
          eid = q_id.pop_front();
          ed  = q_d.pop_front();
          if (rsp_id !== 2'(eid) || rsp_data !== ed) begin
            failures++; $display("FAIL rr_rsp got id=%0d data=%h exp id=%0d data=%h", rsp_id, rsp_data, eid, ed);
          end
        end
        nr++;
      end
      tick();
      if (g >= 0) req_data[8*g +: 8] = 8'($urandom);
    end
    checks++;
    if (ng != 5 || nr != 5) begin
      failures++; $display("FAIL rr_count got grants=%0d rsps=%0d exp 5/5", ng, nr);
    end
  endtask

  task automatic test_lock();
    logic [7:0] seq_cmd [7];
    int exp_id [8];
    logic [7:0] exp_dat [8];
    logic [7:0] r1cmd, r1data;
    int ng = 0, nr = 0, issued2 = 0, acc;
    do_reset();
    seq_cmd = '{MI_CHIP_ENABLE, M_NAND_READ_ID, MI_GET_ID_BYTE, MI_GET_ID_BYTE,
                MI_GET_ID_BYTE, MI_GET_ID_BYTE, MI_GET_ID_BYTE};
    r1cmd  = 8'($urandom_range(32, 255));
    r1data = 8'($urandom);
    exp_id  = '{2, 2, 2, 2, 2, 2, 2, 1};
    exp_dat = '{nand_fn(MI_CHIP_ENABLE, 8'h00), nand_fn(M_NAND_READ_ID, 8'h00),
                8'h2C, 8'hE5, 8'hFF, 8'h03, 8'h86, nand_fn(r1cmd, r1data)};
    req_lock[2] = 1'b1;
    req_valid[2] = 1'b1;
    req_cmd[23:16] = seq_cmd[0];
    for (int c = 0; c < 150 && nr < 8; c++) begin
      @(negedge clk);
      acc = -1;
      if (req_ready != '0) begin
        for (int i = 0; i < N; i++) if (req_ready[i]) acc = i;
        checks++;
        if (ng >= 8) begin
          failures++; $display("FAIL lock_grant extra got=%b", req_ready);
        end else if (req_ready !== (N'(1) << exp_id[ng])) begin
          failures++; $display("FAIL lock_grant n=%0d got=%b exp_idx=%0d", ng, req_ready, exp_id[ng]);
        end
        ng++;
      end
      if (rsp_valid) begin
        checks++;
        if (nr < 8 && (rsp_id !== 2'(exp_id[nr]) || rsp_data !== exp_dat[nr])) begin
          failures++; $display("FAIL lock_rsp n=%0d got id=%0d data=%h exp id=%0d data=%h", nr, rsp_id, rsp_data, exp_id[nr], exp_dat[nr]);
        end
        nr++;
      end
      tick();
      if (c == 0) begin
        req_valid[1] = 1'b1;
        req_cmd[15:8] = r1cmd;
        req_data[15:8] = r1data;
      end
      if (acc == 2) begin
        issued2++;
        if (issued2 < 7) req_cmd[23:16] = seq_cmd[issued2];
        else begin
          req_valid[2] = 1'b0;
          req_lock[2] = 1'b0;
        end
      end
      if (acc == 1) req_valid[1] = 1'b0;
    end
    checks++;
    if (nr != 8) begin
      failures++; $display("FAIL lock_count got rsps=%0d exp=8", nr);
    end
  endtask

  task automatic test_busy_wait();
    int fall = -1, rspc = -1, stray = 0;
    logic prev_busy = 1'b0;
    do_reset();
    busy_len = 40;
    req_valid = 4'b0001;
    req_cmd[7:0] = MI_GET_STATUS;
    for (int c = 0; c < 100 && rspc < 0; c++) begin
      @(negedge clk);
      if (c == 0) begin
        checks++;
        if (req_ready !== 4'b0001) begin
          failures++; $display("FAIL busy_accept got=%b exp=0001", req_ready);
        end
      end else if (req_ready !== '0) stray++;
      if (prev_busy && !m_busy && fall < 0) fall = c;
      prev_busy = m_busy;
      if (rsp_valid && rspc < 0) rspc = c;
      tick();
      if (c == 0) req_valid = 4'b1110;
    end
    checks++;
    if (stray != 0) begin
      failures++; $display("FAIL busy_stray_ready got=%0d exp=0", stray);
    end
    checks++;
    if (fall != 42) begin
      failures++; $display("FAIL busy_fall_cycle got=%0d exp=42", fall);
    end
    checks++;
    if (rspc != 43) begin
      failures++; $display("FAIL busy_rsp_cycle got=%0d exp=43", rspc);
    end
  endtask

  task automatic test_timeout();
    int rspc;
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      // pass 0: busy outlives the 16-cycle window; pass 1: busy falls on its last cycle
      busy_len = (pass == 0) ? 1000 : 16;
      req_valid = 4'b0001;
      req_cmd[7:0] = 8'h55;
      req_data[7:0] = 8'h12;
      rspc = -1;
      for (int c = 0; c < 40 && rspc < 0; c++) begin
        @(negedge clk);
        if (to_rsp_valid) begin
          rspc = c;
          checks++;
          if (pass == 0 && (to_rsp_err !== 1'b1 || to_rsp_data !== 8'h00)) begin
            failures++; $display("FAIL timeout_err got err=%b data=%h exp err=1 data=00", to_rsp_err, to_rsp_data);
          end
          if (pass == 1 && (to_rsp_err !== 1'b0 || to_rsp_data !== nand_fn(8'h55, 8'h12))) begin
            failures++; $display("FAIL timeout_tie got err=%b data=%h exp err=0 data=%h", to_rsp_err, to_rsp_data, nand_fn(8'h55, 8'h12));
          end
        end
        tick();
        if (c == 0) req_valid = '0;
      end
      checks++;
      if (rspc != 19) begin
        failures++; $display("FAIL timeout_cycle pass=%0d got=%0d exp=19", pass, rspc);
      end
    end
  endtask

  task automatic test_reset_wait();
    int nrsp = 0;
    do_reset();
    busy_len = 1000;
    req_valid = 4'b0001;
    req_cmd[7:0] = 8'h77;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      tick();
      if (c == 0) req_valid = '0;
    end
    reset = 1'b1;
    busy_len = 0;
    req_valid = 4'b1111;
    @(negedge clk);
    checks++;
    if (req_ready !== '0) begin
      failures++; $display("FAIL rstwait_ready_in_reset got=%b exp=0000", req_ready);
    end
    tick();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({m_activate, rsp_valid, rsp_err, rsp_id, m_cmd_in, m_data_in, rsp_data} !== 29'h0) begin
      failures++; $display("FAIL rstwait_outputs got act=%b v=%b err=%b id=%0d cmd=%h din=%h d=%h exp all 0",
                           m_activate, rsp_valid, rsp_err, rsp_id, m_cmd_in, m_data_in, rsp_data);
    end
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++; $display("FAIL rstwait_first_grant got=%b exp=0001", req_ready);
    end
    for (int c = 11; c < 17; c++) begin
      if (c > 11) @(negedge clk);
      if (rsp_valid) begin
        nrsp++;
        checks++;
        if (c != 15 || rsp_id !== 2'd0) begin
          failures++; $display("FAIL rstwait_rsp cyc=%0d id=%0d exp cyc=15 id=0", c, rsp_id);
        end
      end
      tick();
      req_valid = '0;
    end
    checks++;
    if (nrsp != 1) begin
      failures++; $display("FAIL rstwait_rsp_count got=%0d exp=1", nrsp);
    end
  endtask

  task automatic test_random();
    logic [7:0] cmdq [N];
    logic [7:0] datq [N];
    logic [7:0] exp_d = 8'h00;
    logic [N-1:0] exp_ready;
    int last = N - 1, next_ok = 0, exp_rc = -1, exp_id = 0, w, lat;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          cmdq[i] = 8'($urandom_range(32, 255));
          datq[i] = 8'($urandom);
          req_cmd[8*i +: 8]  = cmdq[i];
          req_data[8*i +: 8] = datq[i];
          req_valid[i] = 1'b1;
        end
      end
      w = (c >= next_ok && req_valid != '0) ? rr_next(req_valid, last) : -1;
      exp_ready = (w >= 0) ? (N'(1) << w) : '0;
      @(negedge clk);
      checks++;
      if (req_ready !== exp_ready) begin
        failures++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", c, req_ready, exp_ready);
      end
      checks++;
      if (rsp_valid !== (c == exp_rc)) begin
        failures++; $display("FAIL rand_rsp_valid cyc=%0d got=%b exp=%b", c, rsp_valid, (c == exp_rc));
      end
      if (rsp_valid && c == exp_rc) begin
        checks++;
        if (rsp_id !== 2'(exp_id) || rsp_data !== exp_d || rsp_err !== 1'b0) begin
          failures++; $display("FAIL rand_rsp cyc=%0d got id=%0d data=%h err=%b exp id=%0d data=%h err=0",
                               c, rsp_id, rsp_data, rsp_err, exp_id, exp_d);
        end
      end
      tick();
      if (w >= 0) begin
        lat = $urandom_range(0, 6);
        busy_len = lat;
        exp_rc  = c + ((lat > 1) ? 3 + lat : 4);
        next_ok = exp_rc + 1;
        exp_id  = w;
        exp_d   = nand_fn(cmdq[w], datq[w]);
        last    = w;
        req_valid[w] = 1'b0;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    req_valid = '0; req_lock = '0; req_cmd = '0; req_data = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_lock();
    test_busy_wait();
    test_timeout();
    test_reset_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
